match_pe_dispatch_cluster: RTL
==============================

MATCH_PE_DISPATCH_CLUSTER -- requirements
Module: match_pe_dispatch_cluster

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of match PE ports (1..16).
REQ-002 SHALL have parameter TAG_BITS, default `NUM_JOB_PE_LOG2+`LAZY_LEN_LOG2, request/response tag width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, per-PE in-flight request limit (1..15).
REQ-004 SHALL have parameters SLICE_IDX, default 0; SLICE_SEL_LSB, default `SHARED_MATCH_PE_SLICE_SIZE_LOG2; SLICE_SEL_BITS, default `NUM_JOB_PE_LOG2. Together these select history writes.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-006 SHALL have req_valid in 1, req_ready out 1, req_head_addr in `ADDR_WIDTH, req_history_addr in `ADDR_WIDTH, req_tag in TAG_BITS: the upstream request stream.
REQ-007 SHALL have pe_req_valid out NUM_PE, pe_req_ready in NUM_PE, pe_req_head_addr out `ADDR_WIDTH, pe_req_history_addr out `ADDR_WIDTH, pe_req_tag out TAG_BITS. Address and tag are broadcast to all PE ports.
REQ-008 SHALL have pe_resp_valid in NUM_PE, pe_resp_ready out NUM_PE, pe_resp_tag in NUM_PE*TAG_BITS, pe_resp_match_len in NUM_PE*`MATCH_LEN_WIDTH.
REQ-009 SHALL have resp_valid out 1, resp_ready in 1, resp_tag out TAG_BITS, resp_match_len out `MATCH_LEN_WIDTH.
REQ-010 SHALL have wr_addr in `ADDR_WIDTH, wr_data in `MATCH_PE_WIDTH*8, wr_en in 1, and pe_wr_addr, pe_wr_data, pe_wr_en, pe_wr_history_en outputs of matching widths (pe_wr_history_en is 1 bit).

Function
REQ-011 SHALL define PE i as eligible when pe_req_ready[i]=1 and its outstanding count is below MAX_OUTSTANDING.
REQ-012 SHALL drive req_ready=1 exactly when at least one PE is eligible. With none eligible, req_ready=0 and all pe_req_valid bits are 0.
REQ-013 SHALL assert one-hot pe_req_valid[g]=req_valid for the first eligible PE g found searching from req_ptr upward with wrap, in the same cycle (combinational, zero latency).
REQ-014 SHALL, on an accepted request to PE g, set req_ptr to (g+1) mod NUM_PE. Otherwise req_ptr holds.
REQ-015 SHALL keep a per-PE outstanding counter of width clog2(MAX_OUTSTANDING+1). It increments on request accept to that PE and decrements on response accept from that PE. Both in the same cycle leave it unchanged. A decrement at 0 saturates at 0.
REQ-016 SHALL select responses round-robin from resp_ptr among asserted pe_resp_valid. At most one pe_resp_ready bit is high per cycle, and only when the output register is empty or resp_ready=1.
REQ-017 SHALL capture the accepted response (tag, match_len) into a single output register, which presents it on resp_* the following cycle (latency 1). A full register sustains one response per cycle when resp_ready=1.
REQ-018 SHALL hold resp_valid, resp_tag and resp_match_len stable while resp_valid=1 and resp_ready=0.
REQ-019 SHALL, on a response accept from PE h, set resp_ptr to (h+1) mod NUM_PE.
REQ-020 SHALL register wr_addr, wr_data and wr_en once to produce pe_wr_addr, pe_wr_data and pe_wr_en (latency 1).
REQ-021 SHALL register pe_wr_history_en as (wr_addr[SLICE_SEL_LSB +: SLICE_SEL_BITS]==SLICE_IDX[SLICE_SEL_BITS-1:0]), aligned with pe_wr_addr.
REQ-022 SHALL, with NUM_PE=1, keep both pointers constantly 0 and operate as a rate-limited pass-through.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, clear all outstanding counters, req_ptr, resp_ptr, resp_valid and pe_wr_en to 0.
REQ-024 SHALL drive req_ready=0 and pe_resp_ready=0 during any cycle with rst=1. Responses arriving after a mid-operation reset SHALL NOT underflow the counters (REQ-015 saturation).

Configuration
REQ-025 SHALL, when MATCH_CLUSTER_PERF_CNT_EN is defined, add outputs perf_req_cnt (32) and perf_stall_cnt (32). These count accepted requests and cycles with req_valid=1 and req_ready=0, wrap at 2^32, and clear on reset.
REQ-026 SHALL, when MATCH_CLUSTER_PERF_CNT_EN is undefined, omit both ports and their logic, with all other behaviour identical.

Verification
REQ-027 SHALL cover this scenario: NUM_PE=4, all pe_req_ready=1, no responses, 8 back-to-back requests. Grants SHALL go to PEs 0,1,2,3,0,1,2,3, and all counters SHALL read 2.
REQ-028 SHALL cover this scenario: MAX_OUTSTANDING=2, pe_req_ready=4'b0001, 3 requests. The first two SHALL be accepted to PE0, then req_ready=0 until PE0 returns a response. After that response is accepted, the third request SHALL be accepted.
REQ-029 SHALL cover this scenario: pe_resp_valid=4'b1111 held for 4 cycles with resp_ready=1. resp_tag SHALL deliver PE0..PE3 tags in order, each 1 cycle after its pe_resp_ready.
REQ-030 SHALL cover this scenario: resp_ready=0 for 5 cycles while resp_valid=1. Outputs SHALL stay stable, and pe_resp_ready SHALL stay 0 after the register fills.
REQ-031 SHALL cover this scenario: wr_addr with selected bits equal to SLICE_IDX, then a non-matching wr_addr. pe_wr_history_en SHALL be 1 then 0, each 1 cycle later, with pe_wr_en following wr_en.
REQ-032 SHALL cover this scenario: rst asserted with 3 outstanding on PE1, then a late response from PE1. The counter SHALL stay 0 and resp_valid=0 during reset; the late response SHALL pass through normally afterwards.

Source files
------------

// File: rtl/match_pe_dispatch_cluster.sv
// Round-robin dispatch of match requests to NUM_PE match PEs with per-PE in-flight limits, response merge and history-write fan-out.
// Optional perf counters are enabled by defining MATCH_CLUSTER_PERF_CNT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MATCH_PE_WIDTH
`define MATCH_PE_WIDTH 4
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 6
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif
`ifndef SHARED_MATCH_PE_SLICE_SIZE_LOG2
`define SHARED_MATCH_PE_SLICE_SIZE_LOG2 4
`endif

module match_pe_dispatch_cluster #(
  parameter int NUM_PE          = 4,
  parameter int TAG_BITS        = `NUM_JOB_PE_LOG2 + `LAZY_LEN_LOG2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SLICE_IDX       = 0,
  parameter int SLICE_SEL_LSB   = `SHARED_MATCH_PE_SLICE_SIZE_LOG2,
  parameter int SLICE_SEL_BITS  = `NUM_JOB_PE_LOG2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [`ADDR_WIDTH-1:0]               req_head_addr,
  input  logic [`ADDR_WIDTH-1:0]               req_history_addr,
  input  logic [TAG_BITS-1:0]                  req_tag,
  output logic [NUM_PE-1:0]                    pe_req_valid,
  input  logic [NUM_PE-1:0]                    pe_req_ready,
  output logic [`ADDR_WIDTH-1:0]               pe_req_head_addr,
  output logic [`ADDR_WIDTH-1:0]               pe_req_history_addr,
  output logic [TAG_BITS-1:0]                  pe_req_tag,
  input  logic [NUM_PE-1:0]                    pe_resp_valid,
  output logic [NUM_PE-1:0]                    pe_resp_ready,
  input  logic [NUM_PE*TAG_BITS-1:0]           pe_resp_tag,
  input  logic [NUM_PE*`MATCH_LEN_WIDTH-1:0]   pe_resp_match_len,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [TAG_BITS-1:0]                  resp_tag,
  output logic [`MATCH_LEN_WIDTH-1:0]          resp_match_len,
  input  logic [`ADDR_WIDTH-1:0]               wr_addr,
  input  logic [`MATCH_PE_WIDTH*8-1:0]         wr_data,
  input  logic                                 wr_en,
  output logic [`ADDR_WIDTH-1:0]               pe_wr_addr,
  output logic [`MATCH_PE_WIDTH*8-1:0]         pe_wr_data,
  output logic                                 pe_wr_en,
  output logic                                 pe_wr_history_en
`ifdef MATCH_CLUSTER_PERF_CNT_EN
  ,
  output logic [31:0]                          perf_req_cnt,
  output logic [31:0]                          perf_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int LEN_W = `MATCH_LEN_WIDTH;
  localparam logic [CNT_W-1:0]          CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SLICE_SEL_BITS-1:0] SLICE_SEL = SLICE_SEL_BITS'(SLICE_IDX);

  // First candidate at or above ptr, then wrap to the ones below it.
  function automatic logic [NUM_PE-1:0] rr_pick(input logic [NUM_PE-1:0] cand,
                                               input logic [PTR_W-1:0]  ptr);
    logic [NUM_PE-1:0] gnt;
    logic              found;
    gnt   = '0;
    found = 1'b0;
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (!found && cand[i] && ((lap == 0) == (i >= int'(ptr)))) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_next_ptr(input logic [NUM_PE-1:0] gnt);
    logic [PTR_W-1:0] nxt;
    nxt = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (gnt[i]) nxt = (i + 1 >= NUM_PE) ? '0 : PTR_W'(i + 1);
    end
    return nxt;
  endfunction

  logic [PTR_W-1:0]    req_ptr_q, req_ptr_d;
  logic [PTR_W-1:0]    resp_ptr_q, resp_ptr_d;
  logic [CNT_W-1:0]    out_cnt_q [NUM_PE];
  logic [CNT_W-1:0]    out_cnt_d [NUM_PE];
  logic [NUM_PE-1:0]   elig;
  logic [NUM_PE-1:0]   req_gnt;
  logic [NUM_PE-1:0]   resp_gnt;
  logic                req_acc;
  logic                resp_take;
  logic                resp_acc;
  logic                resp_valid_q, resp_valid_d;
  logic [TAG_BITS-1:0] resp_tag_q, resp_tag_d;
  logic [LEN_W-1:0]    resp_len_q, resp_len_d;
  logic [`ADDR_WIDTH-1:0]       pe_wr_addr_q;
  logic [`MATCH_PE_WIDTH*8-1:0] pe_wr_data_q;
  logic                         pe_wr_en_q;
  logic                         pe_wr_hist_q;

  // Request dispatch: combinational grant, zero latency.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      elig[i] = pe_req_ready[i] && (out_cnt_q[i] < CNT_MAX);
    end
    req_gnt   = rr_pick(elig, req_ptr_q);
    req_ready = !rst && (|req_gnt);
    pe_req_valid = (req_valid && !rst) ? req_gnt : '0;
    req_acc   = req_valid && req_ready;
    req_ptr_d = req_acc ? onehot_to_next_ptr(req_gnt) : req_ptr_q;
  end

  assign pe_req_head_addr    = req_head_addr;
  assign pe_req_history_addr = req_history_addr;
  assign pe_req_tag          = req_tag;

  // Response merge into a single output register.
  always_comb begin
    resp_gnt      = rr_pick(pe_resp_valid, resp_ptr_q);
    resp_take     = !rst && (!resp_valid_q || resp_ready);
    pe_resp_ready = resp_take ? resp_gnt : '0;
    resp_acc      = resp_take && (|resp_gnt);
    resp_ptr_d    = resp_acc ? onehot_to_next_ptr(resp_gnt) : resp_ptr_q;
    resp_tag_d    = resp_tag_q;
    resp_len_d    = resp_len_q;
    for (int i = 0; i < NUM_PE; i++) begin
      if (resp_acc && resp_gnt[i]) begin
        resp_tag_d = pe_resp_tag[i*TAG_BITS +: TAG_BITS];
        resp_len_d = pe_resp_match_len[i*LEN_W +: LEN_W];
      end
    end
    if (resp_acc)        resp_valid_d = 1'b1;
    else if (resp_ready) resp_valid_d = 1'b0;
    else                 resp_valid_d = resp_valid_q;
  end

  // Decrement at zero saturates so stale responses after a reset are harmless.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if (req_acc && req_gnt[i] && !pe_resp_ready[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + 1'b1;
      end else if (!(req_acc && req_gnt[i]) && pe_resp_ready[i] && (out_cnt_q[i] != '0)) begin
        out_cnt_d[i] = out_cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ptr_q    <= '0;
      resp_ptr_q   <= '0;
      resp_valid_q <= 1'b0;
      pe_wr_en_q   <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) out_cnt_q[i] <= '0;
    end else begin
      req_ptr_q    <= req_ptr_d;
      resp_ptr_q   <= resp_ptr_d;
      resp_valid_q <= resp_valid_d;
      pe_wr_en_q   <= wr_en;
      for (int i = 0; i < NUM_PE; i++) out_cnt_q[i] <= out_cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    resp_tag_q   <= resp_tag_d;
    resp_len_q   <= resp_len_d;
    pe_wr_addr_q <= wr_addr;
    pe_wr_data_q <= wr_data;
    pe_wr_hist_q <= (wr_addr[SLICE_SEL_LSB +: SLICE_SEL_BITS] == SLICE_SEL);
  end

  assign resp_valid       = resp_valid_q;
  assign resp_tag         = resp_tag_q;
  assign resp_match_len   = resp_len_q;
  assign pe_wr_addr       = pe_wr_addr_q;
  assign pe_wr_data       = pe_wr_data_q;
  assign pe_wr_en         = pe_wr_en_q;
  assign pe_wr_history_en = pe_wr_hist_q;

`ifdef MATCH_CLUSTER_PERF_CNT_EN
  logic [31:0] perf_req_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (req_acc)                perf_req_q   <= perf_req_q + 32'd1;
      if (req_valid && !req_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_req_cnt   = perf_req_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
